llr_loader: RTL and testbench

Write-side feeder for the polar decoder's LLR storage. On a start command it fetches one codeword's LLRs from the external 64-bit LLR SRAM and presents them as a stream of 8-LLR write beats (o_wen/o_data/o_code) to the LLR shift memory. Beats are issued in descending address order so that, after the final beat, LLR index 0 sits at memory position 0. The block sits between the top-level controller and the LLR memory and signals completion so the decode FSM can begin.

---
 rtl/llr_pkg.sv | 40 ++++
 rtl/llr_loader_if.sv | 37 +++
 rtl/llr_rd_pipe.sv | 64 ++++++
 rtl/llr_loader.sv | 128 ++++++++++++
 tb/tb_llr_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/llr_pkg.sv
// ============================================================================
// Module      : llr_pkg
// Description : Shared types and constants for the LLR loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package llr_pkg;

    typedef enum logic [1:0] {
        CODE_64   = 2'd0,
        CODE_256  = 2'd1,
        CODE_1024 = 2'd2,
        CODE_BAD  = 2'd3
    } code_e;

    localparam int WORDS_64   = 8;
    localparam int WORDS_256  = 32;
    localparam int WORDS_1024 = 128;
    localparam int CNT_W      = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Index of the highest SRAM word of a codeword (W-1).
    function automatic logic [CNT_W-1:0] last_word_idx(input code_e code);
        case (code)
            CODE_64:  return CNT_W'(WORDS_64 - 1);
            CODE_256: return CNT_W'(WORDS_256 - 1);
            default:  return CNT_W'(WORDS_1024 - 1);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/llr_loader_if.sv
// ============================================================================
// Module      : llr_loader_if
// Description : Command, SRAM read and LLR-memory write signals of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface llr_loader_if #(
    parameter int ADDR_W = 12
);
    logic              i_start;
    logic [1:0]        i_code;
    logic [ADDR_W-1:0] i_base_addr;
    logic              o_mem_ren;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [63:0]       i_mem_rdata;
    logic              o_wen;
    logic [63:0]       o_data;
    logic [1:0]        o_code;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    // Controller / SRAM side
    modport master (
        output i_start, i_code, i_base_addr, i_mem_rdata,
        input  o_mem_ren, o_mem_addr, o_wen, o_data, o_code, o_busy, o_done, o_err
    );

    // Loader side
    modport slave (
        input  i_start, i_code, i_base_addr, i_mem_rdata,
        output o_mem_ren, o_mem_addr, o_wen, o_data, o_code, o_busy, o_done, o_err
    );
endinterface

`default_nettype wire

// File: rtl/llr_rd_pipe.sv
// ============================================================================
// Module      : llr_rd_pipe
// Description : SRAM read-latency valid pipe and output beat register.
//               LLR_LOADER_SAT_EN: clamp each LLR magnitude to 63.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module llr_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        ren,
    input  wire logic [63:0] rdata,
    output logic             wen,
    output logic [63:0]      data,
    output logic             pending
);

    logic [RD_LAT-1:0] vld;
    logic [63:0]       fmt;

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) vld <= '0;
                else        vld <= ren;
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (!rst_n) vld <= '0;
                else        vld <= {vld[RD_LAT-2:0], ren};
            end
        end
    endgenerate

`ifdef LLR_LOADER_SAT_EN
    // Magnitude above 63 means bit 6 is set; keep the sign, force 63.
    always_comb begin
        fmt = rdata;
        for (int k = 0; k < 8; k++) begin
            if (rdata[8*k+6]) fmt[8*k +: 7] = 7'h3F;
        end
    end
`else
    assign fmt = rdata;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen  <= 1'b0;
            data <= '0;
        end else begin
            wen <= vld[RD_LAT-1];
            if (vld[RD_LAT-1]) data <= fmt;
        end
    end

    assign pending = |vld;

endmodule

`default_nettype wire

// File: rtl/llr_loader.sv
// ============================================================================
// Module      : llr_loader
// Description : Fetches one codeword of LLRs from SRAM, highest word first,
//               and streams them as 8-LLR write beats to the LLR memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module llr_loader
    import llr_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst_n,
    llr_loader_if.slave bus
);

    state_e             state, state_nxt;
    logic               mem_ren, ren_nxt;
    logic [ADDR_W-1:0]  mem_addr, addr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         code_q, code_nxt;
    logic               busy, busy_nxt;
    logic               done, done_nxt;
    logic               err, err_nxt;
    logic               wen;
    logic [63:0]        data;
    logic               pipe_pending;
    logic [CNT_W-1:0]   start_idx;

    assign start_idx = last_word_idx(code_e'(bus.i_code));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            mem_ren  <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
            code_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_ren  <= ren_nxt;
            mem_addr <= addr_nxt;
            cnt      <= cnt_nxt;
            code_q   <= code_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ren_nxt   = mem_ren;
        addr_nxt  = mem_addr;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_code == CODE_BAD) begin
                        err_nxt = 1'b1;
                    end else begin
                        code_nxt  = bus.i_code;
                        cnt_nxt   = start_idx;
                        addr_nxt  = bus.i_base_addr + ADDR_W'(start_idx);
                        ren_nxt   = 1'b1;
                        busy_nxt  = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (cnt == '0) begin
                    ren_nxt   = 1'b0;
                    state_nxt = ST_DRAIN;
                end else begin
                    addr_nxt = mem_addr - ADDR_W'(1);
                    cnt_nxt  = cnt - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // Pipe empty while the final beat is on the bus.
                if (!pipe_pending && wen) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    llr_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .ren     (mem_ren),
        .rdata   (bus.i_mem_rdata),
        .wen     (wen),
        .data    (data),
        .pending (pipe_pending)
    );

    assign bus.o_mem_ren  = mem_ren;
    assign bus.o_mem_addr = mem_addr;
    assign bus.o_wen      = wen;
    assign bus.o_data     = data;
    assign bus.o_code     = code_q;
    assign bus.o_busy     = busy;
    assign bus.o_done     = done;
    assign bus.o_err      = err;

endmodule

`default_nettype wire

// File: tb/tb_llr_loader.sv
// ============================================================================
// Module      : tb_llr_loader
// Description : Self-checking bench: SRAM model, event monitor, table-driven
//               and random loads against an address/beat reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_llr_loader;

    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   t0 = 0;

    logic [63:0] mem [0:4095];
    logic [63:0] dq  [LAT];

    int          rd_cyc[$];
    logic [11:0] rd_addr[$];
    int          wb_cyc[$];
    logic [63:0] wb_data[$];
    int          done_cyc[$];
    int          done_code[$];
    int          err_cyc[$];
    int          busy_q[$];

    typedef struct {
        int          code;
        int          base;
        int          words;
        logic [11:0] first;
        logic [11:0] last;
        int          done_off;
    } vec_t;

    llr_loader_if #(.ADDR_W(12)) bus ();

    llr_loader #(
        .ADDR_W (12),
        .RD_LAT (LAT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: data valid LAT cycles after the read enable; junk otherwise
    always @(posedge clk) begin
        dq[0] <= bus.o_mem_ren ? mem[bus.o_mem_addr] : {$urandom, $urandom};
        for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
    end
    assign bus.i_mem_rdata = dq[LAT-1];

    always @(negedge clk) begin
        if (bus.o_mem_ren) begin rd_cyc.push_back(cyc); rd_addr.push_back(bus.o_mem_addr); end
        if (bus.o_wen)     begin wb_cyc.push_back(cyc); wb_data.push_back(bus.o_data); end
        if (bus.o_done)    begin done_cyc.push_back(cyc); done_code.push_back(int'(bus.o_code)); end
        if (bus.o_err)     err_cyc.push_back(cyc);
        if (bus.o_busy)    busy_q.push_back(cyc);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [63:0] w);
        logic [63:0] r;
        r = w;
`ifdef LLR_LOADER_SAT_EN
        for (int k = 0; k < 8; k++) begin
            if (int'(w[8*k +: 7]) > 63) r[8*k +: 7] = 7'd63;
        end
`endif
        return r;
    endfunction

    task automatic clear_q();
        rd_cyc.delete(); rd_addr.delete(); wb_cyc.delete(); wb_data.delete();
        done_cyc.delete(); done_code.delete(); err_cyc.delete(); busy_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {58'd0, bus.o_mem_ren, bus.o_wen, bus.o_busy, bus.o_done, bus.o_err, 1'b0}, 64'd0);
        chk({tag, "_code"}, {62'd0, bus.o_code}, 64'd0);
        chk({tag, "_addr"}, {52'd0, bus.o_mem_addr}, 64'd0);
        chk({tag, "_data"}, bus.o_data, 64'd0);
    endtask

    // One load; inject > 0 pulses a second (different) start that many cycles in.
    task automatic run_load(input int code, input int base, input int inject);
        int w;
        int nrd;
        int nwb;
        w = (code == 0) ? 8 : (code == 1) ? 32 : 128;
        clear_q();
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_code = 2'(code); bus.i_base_addr = 12'(base);
        @(negedge clk);
        t0 = cyc - 1;
        bus.i_start = 1'b0; bus.i_code = 2'($urandom); bus.i_base_addr = 12'($urandom);
        if (inject > 0) begin
            repeat (inject) @(negedge clk);
            bus.i_start = 1'b1; bus.i_code = 2'((code + 1) % 3); bus.i_base_addr = 12'($urandom);
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        for (int i = 0; i < 400 && done_cyc.size() == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);

        nrd = 0;
        for (int k = 0; k < w; k++) begin
            if (k >= rd_addr.size()) nrd++;
            else if (rd_addr[k] != 12'((base + w - 1 - k) & 4095) || rd_cyc[k] != t0 + 1 + k) nrd++;
        end
        nwb = 0;
        for (int k = 0; k < w; k++) begin
            if (k >= wb_data.size()) nwb++;
            else if (wb_data[k] !== exp_word(mem[12'((base + w - 1 - k) & 4095)]) ||
                     wb_cyc[k] != t0 + 2 + LAT + k) nwb++;
        end
        chk("read_count", 64'(rd_addr.size()), 64'(w));
        chk("read_seq_errors", 64'(nrd), 64'd0);
        chk("beat_count", 64'(wb_data.size()), 64'(w));
        chk("beat_seq_errors", 64'(nwb), 64'd0);
        chk("done_count", 64'(done_cyc.size()), 64'd1);
        chk("done_cycle", 64'(done_cyc.size() > 0 ? done_cyc[0] - t0 : -1), 64'(2 + LAT + w));
        chk("code_at_done", 64'(done_code.size() > 0 ? done_code[0] : -1), 64'(code));
        chk("busy_cycles", 64'(busy_q.size()), 64'(w + 2 + LAT));
        chk("no_err", 64'(err_cyc.size()), 64'd0);
    endtask

    initial begin
        vec_t tab[4];
        int   e;
        logic [63:0] sat_in;
        logic [63:0] sat_exp;

        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
        bus.i_start = 1'b0; bus.i_code = 2'd0; bus.i_base_addr = 12'd0;

        tab[0] = '{code: 0, base: 12'h010, words: 8,   first: 12'h017, last: 12'h010, done_off: 11};
        tab[1] = '{code: 1, base: 12'h123, words: 32,  first: 12'h142, last: 12'h123, done_off: 35};
        tab[2] = '{code: 2, base: 12'hFF0, words: 128, first: 12'h06F, last: 12'hFF0, done_off: 131};
        tab[3] = '{code: 0, base: 12'hFFC, words: 8,   first: 12'h003, last: 12'hFFC, done_off: 11};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_load(tab[v].code, tab[v].base, 0);
            chk("tab_words", 64'(rd_addr.size()), 64'(tab[v].words));
            chk("tab_first_addr", 64'(rd_addr.size() > 0 ? rd_addr[0] : 12'hBAD), 64'(tab[v].first));
            chk("tab_last_addr", 64'(rd_addr.size() > 0 ? rd_addr[rd_addr.size()-1] : 12'hBAD), 64'(tab[v].last));
            chk("tab_done_off", 64'(done_cyc.size() > 0 ? done_cyc[0] - t0 : -1), 64'(tab[v].done_off));
        end

        // Illegal code
        clear_q();
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_code = 2'd3; bus.i_base_addr = 12'h040;
        @(negedge clk);
        t0 = cyc - 1;
        bus.i_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("err_count", 64'(err_cyc.size()), 64'd1);
        chk("err_cycle", 64'(err_cyc.size() > 0 ? err_cyc[0] - t0 : -1), 64'd1);
        chk("err_side_effects", 64'(rd_addr.size() + wb_data.size() + busy_q.size()), 64'd0);

        // Start during FETCH is ignored
        run_load(1, 12'h555, 3);

        // Reset on the 5th beat, then a clean load
        clear_q();
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_code = 2'd1; bus.i_base_addr = 12'h200;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int i = 0; i < 100 && wb_data.size() < 5; i++) @(negedge clk);
        chk("beats_before_reset", 64'(wb_data.size()), 64'd5);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        clear_q();
        repeat (10) @(negedge clk);
        chk("post_reset_quiet", 64'(done_cyc.size() + wb_data.size() + rd_addr.size() + busy_q.size()), 64'd0);
        run_load(1, 12'h200, 0);

        // Saturation bytes at the first beat's word
        sat_in = 64'h80C0403F057FFF00;
`ifdef LLR_LOADER_SAT_EN
        sat_exp = 64'h80BF3F3F053FBF00;
`else
        sat_exp = 64'h80C0403F057FFF00;
`endif
        mem[12'h307] = sat_in;
        run_load(0, 12'h300, 0);
        chk("sat_word", wb_data.size() > 0 ? wb_data[0] : 64'd0, sat_exp);

        // Random loads
        for (int r = 0; r < 6; r++) begin
            e = $urandom_range(0, 2);
            run_load(e, $urandom_range(0, 4095), (r % 2 == 1) ? $urandom_range(1, 6) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
